// File: rtl/rc4_defs_pkg.sv
// Phase codes and feeder state encodings shared by the RC4 key feeder and key_gene.
package rc4_defs;

    typedef enum logic [1:0] {
        INIT       = 2'b00,
        KEY_GENE   = 2'b01,
        EN_DE_CODE = 2'b10
    } ns_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        KSA  = 2'b01,
        WAIT = 2'b10,
        RUN  = 2'b11
    } state_t;

    // Index of the last of the 256 key bytes streamed during the schedule.
    localparam logic [8:0] LAST_IDX = 9'd255;

    function automatic ns_t ns_of(input state_t s);
        case (s)
            IDLE:      return INIT;
            KSA, WAIT: return KEY_GENE;
            RUN:       return EN_DE_CODE;
            default:   return INIT;
        endcase
    endfunction

endpackage

// File: rtl/rc4_key_store.sv
// Key byte register file: one write port, one registered read port.
// Only the read register is reset; the stored bytes keep their contents.
module rc4_key_store #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rc4_key_feeder.sv
// Sequences the RC4 key schedule: streams key[i mod len] for 256 cycles, then waits for
// data_rready before releasing the core.
//
//   state | meaning
//   IDLE  | NS=INIT, key store writable, waiting for start
//   KSA   | NS=KEY_GENE, one key byte per cycle, idx 0..255
//   WAIT  | NS=KEY_GENE, last byte held, waiting for data_rready or timeout
//   RUN   | NS=EN_DE_CODE, ready high, start re-runs the schedule
module rc4_key_feeder
    import rc4_defs::*;
#(
    parameter int KEY_MAX     = 16,
    parameter int RDY_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_wr,
    input  logic [7:0] key_byte,
    input  logic       key_clr,
    input  logic       start,
    input  logic       data_rready,
    output logic [1:0] NS,
    output logic [7:0] key_init,
    output logic       busy,
    output logic       ready,
    output logic       err
);

    localparam int KW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
    localparam int LW = $clog2(KEY_MAX + 1);
    localparam int TW = $clog2(RDY_TIMEOUT + 1);

    state_t        state, state_next;
    ns_t           ns_q;
    logic [LW-1:0] key_len;
    logic [LW-1:0] ksa_len;
    logic [8:0]    idx;
    logic [KW-1:0] kidx;
    logic [KW-1:0] kidx_wrap;
    logic [KW-1:0] rd_addr;
    logic [TW-1:0] tmo;
    logic [TW-1:0] tmo_inc;
    logic          err_next;
    logic          load_ksa;
    logic          step_ksa;
    logic          wr_en;
    logic          rd_en;

    // Wrap counter instead of a modulo: kidx walks 0..ksa_len-1 and folds back to 0.
    assign kidx_wrap = (LW'(kidx) + LW'(1) == ksa_len) ? '0 : kidx + KW'(1);
    assign tmo_inc   = tmo + TW'(1);

    assign wr_en   = (state == IDLE) && key_wr && !key_clr && (key_len != LW'(KEY_MAX));
    assign rd_en   = load_ksa || step_ksa;
    assign rd_addr = load_ksa ? '0 : kidx_wrap;

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        load_ksa   = 1'b0;
        step_ksa   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (key_len == '0) begin
                        err_next = 1'b1;
                    end else begin
                        load_ksa   = 1'b1;
                        state_next = KSA;
                    end
                end
            end
            KSA: begin
                if (idx == LAST_IDX) begin
                    state_next = WAIT;
                end else begin
                    step_ksa = 1'b1;
                end
            end
            WAIT: begin
                if (data_rready) begin
                    state_next = RUN;
                end else if (tmo_inc == TW'(RDY_TIMEOUT)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (start) begin
                    load_ksa   = 1'b1;
                    state_next = KSA;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ns_q    <= INIT;
            busy    <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
            key_len <= '0;
            ksa_len <= '0;
            idx     <= '0;
            kidx    <= '0;
            tmo     <= '0;
        end else begin
            state <= state_next;
            ns_q  <= ns_of(state_next);
            busy  <= (state_next == KSA) || (state_next == WAIT);
            ready <= (state_next == RUN);
            err   <= err_next;

            if ((state == IDLE) && key_clr) begin
                key_len <= '0;
            end else if (wr_en) begin
                key_len <= key_len + LW'(1);
            end

            // ksa_len snapshots the pre-write length so a same-cycle write waits for the next start.
            if (load_ksa) begin
                ksa_len <= key_len;
                idx     <= '0;
                kidx    <= '0;
            end else if (step_ksa) begin
                idx  <= idx + 9'd1;
                kidx <= kidx_wrap;
            end

            if ((state == WAIT) && (state_next == WAIT)) begin
                tmo <= tmo_inc;
            end else begin
                tmo <= '0;
            end
        end
    end

    assign NS = ns_q;

    rc4_key_store #(
        .DEPTH (KEY_MAX),
        .AW    (KW)
    ) u_key_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (key_len[KW-1:0]),
        .wr_data (key_byte),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (key_init)
    );

endmodule
